// File: rtl/aes_round_sequencer_if.sv
// Handshake/status bundle between the AES round sequencer and its user.
// The optional decrypt request exists only when AES_SEQ_DECRYPT_EN is defined.
interface aes_round_sequencer_if;
   logic       load;
   logic [1:0] key_mode;
`ifdef AES_SEQ_DECRYPT_EN
   logic       decrypt;
`endif
   logic [3:0] round;
   logic       round_start;
   logic       round_last;
   logic       busy;
   logic       done;
   logic [3:0] nr;

`ifdef AES_SEQ_DECRYPT_EN
   modport master (output load, key_mode, decrypt,
                   input  round, round_start, round_last, busy, done, nr);
   modport slave  (input  load, key_mode, decrypt,
                   output round, round_start, round_last, busy, done, nr);
`else
   modport master (output load, key_mode,
                   input  round, round_start, round_last, busy, done, nr);
   modport slave  (input  load, key_mode,
                   output round, round_start, round_last, busy, done, nr);
`endif
endinterface

// File: rtl/aes_round_sequencer.sv
// AES-128/192/256 round sequencer: INIT (round 0), Nr rounds of ROUND_CYCLES each, then a held DONE.
// Optional macro AES_SEQ_DECRYPT_EN adds a decrypt input that reverses the round order.
module aes_round_sequencer #(
   parameter int ROUND_CYCLES = 4,
   parameter int DONE_HOLD    = 511,
   parameter int CNT_W        = 9
) (
   input logic                  clk,
   input logic                  nreset,
   aes_round_sequencer_if.slave seq_io
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_INIT  = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(ROUND_CYCLES - 1);
   localparam logic [CNT_W-1:0] DH_LAST = CNT_W'(DONE_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   function automatic logic [3:0] nr_of_mode(input logic [1:0] mode);
      case (mode)
         2'b01:   return 4'd12;
         2'b10:   return 4'd14;
         default: return 4'd10;
      endcase
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       round_q, round_d;
   logic [3:0]       nr_q, nr_d;
   logic             dec_q, dec_d;
   logic             round_start_q, round_start_d;
   logic             round_last_q, round_last_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             dec_in_s;
   logic [3:0]       start_nr_s;
   logic [3:0]       first_round_s;
   logic [3:0]       last_round_s;
   logic [3:0]       step_round_s;

`ifdef AES_SEQ_DECRYPT_EN
   assign dec_in_s = seq_io.decrypt;
`else
   assign dec_in_s = 1'b0;
`endif

   // Round ordering: encrypt walks 1..nr, decrypt walks nr-1..0.
   assign start_nr_s    = nr_of_mode(seq_io.key_mode);
   assign first_round_s = dec_q ? (nr_q - 4'd1) : 4'd1;
   assign last_round_s  = dec_q ? 4'd0 : nr_q;
   assign step_round_s  = dec_q ? (round_q - 4'd1) : (round_q + 4'd1);

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      round_d       = round_q;
      nr_d          = nr_q;
      dec_d         = dec_q;
      round_start_d = 1'b0;
      round_last_d  = round_last_q;
      busy_d        = busy_q;
      done_d        = done_q;
      case (state_q)
         S_IDLE: begin
            if (seq_io.load) begin
               state_d       = S_INIT;
               nr_d          = start_nr_s;
               dec_d         = dec_in_s;
               round_d       = dec_in_s ? start_nr_s : 4'd0;
               cnt_d         = '0;
               round_start_d = 1'b1;
               round_last_d  = 1'b0;
               busy_d        = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_INIT: begin
            state_d       = S_ROUND;
            cnt_d         = '0;
            round_d       = first_round_s;
            round_start_d = 1'b1;
            round_last_d  = (first_round_s == last_round_s);
         end
         S_ROUND: begin
            if (cnt_q == RC_LAST) begin
               cnt_d = '0;
               if (round_q == last_round_s) begin
                  state_d      = S_DONE;
                  round_d      = 4'd0;
                  round_last_d = 1'b0;
                  busy_d       = 1'b0;
                  done_d       = 1'b1;
               end else begin
                  round_d       = step_round_s;
                  round_start_d = 1'b1;
                  round_last_d  = (step_round_s == last_round_s);
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DONE: begin
            // Leaving needs load low so a held load cannot retrigger.
            if (cnt_q == DH_LAST) begin
               if (!seq_io.load) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b0;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         round_q       <= 4'd0;
         nr_q          <= 4'd10;
         dec_q         <= 1'b0;
         round_start_q <= 1'b0;
         round_last_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         round_q       <= round_d;
         nr_q          <= nr_d;
         dec_q         <= dec_d;
         round_start_q <= round_start_d;
         round_last_q  <= round_last_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign seq_io.round       = round_q;
   assign seq_io.round_start = round_start_q;
   assign seq_io.round_last  = round_last_q;
   assign seq_io.busy        = busy_q;
   assign seq_io.done        = done_q;
   assign seq_io.nr          = nr_q;

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Parametrised round sequencer for the AES core. Successor to the fixed 10-round next-state controller.
- Sequences the initial AddRoundKey step and rounds 1..Nr for AES-128, AES-192 or AES-256, with Nr selected at start.
- Each round lasts a parametrised number of cycles, to cover the synchronous sbox pipeline in sub_bytes and expand_key.
- Drives round index and strobes to the datapath and key expansion, then holds done for a programmable time.

Parameters:
- ROUND_CYCLES, 4: cycles per round 1..Nr. Legal range 1..255.
- DONE_HOLD, 511: minimum cycles done stays high. Legal range 1..511.
- CNT_W, 9: counter width. Must satisfy 2^CNT_W > max(ROUND_CYCLES, DONE_HOLD).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- nreset  input  1  reset, synchronous and active-low; sampled on the rising clk edge.
- load  input  1  start request, level; sampled only in IDLE and DONE.
- key_mode  input  2  00 = AES-128 (Nr=10), 01 = AES-192 (Nr=12), 10 = AES-256 (Nr=14), 11 = treated as 00. Latched on start.
- round  output  4  current round/key-schedule index.
- round_start  output  1  one-cycle pulse on the first cycle of each round, including round 0.
- round_last  output  1  high for every cycle of the final round; the datapath skips MixColumns.
- busy  output  1  high in INIT and ROUND.
- done  output  1  high in DONE.
- nr  output  4  latched round count for the current operation.

Behaviour:
- Reset: nreset=0 at a rising edge forces IDLE on that edge, including mid-operation. Reset values: counter=0, round=0, nr=10, round_start=0, round_last=0, busy=0, done=0.
- States: IDLE, INIT, ROUND, DONE. All outputs are registered.
- IDLE
  - load=1 at an edge → INIT on that edge.
  - Latch nr from key_mode.
  - round=0, round_start=1, busy=1.
  - load=0 → stay in IDLE.
- INIT (round 0, AddRoundKey only)
  - Exactly 1 cycle.
  - Next edge → ROUND with round=1, counter=0, round_start=1.
- ROUND
  - counter increments every cycle.
  - When counter==ROUND_CYCLES-1 at an edge:
    - if round<nr: round+1, counter=0, round_start=1;
    - if round==nr: → DONE with counter=0, round=0, busy=0, done=1.
  - round_start=0 on all other ROUND cycles.
  - round_last=1 while round==nr.
  - ROUND_CYCLES=1 gives round_start=1 every cycle.
- Latency: INIT entry to DONE entry is exactly 1 + nr*ROUND_CYCLES cycles. With defaults this is 41 / 49 / 57 cycles for AES-128 / 192 / 256.
- DONE
  - counter saturates at DONE_HOLD-1.
  - Exit to IDLE only when counter==DONE_HOLD-1 and load==0.
  - If load is still high after the hold, stay in DONE. This prevents a retrigger from the same load level.
  - A fresh start requires load low, then IDLE, then load high.
- load and key_mode changes during INIT/ROUND are ignored.
- nr holds its value until the next start.
- round never exceeds nr. The counter never wraps because of saturation and the CNT_W rule.

Optional Feature:
- Macro AES_SEQ_DECRYPT_EN.
- Defined:
  - Adds input port decrypt (1 bit), latched on start alongside key_mode.
  - decrypt=1 runs the schedule in reverse: INIT presents round=nr; ROUND steps round nr-1 down to 0.
  - round_last is high while round==0; the exit condition is the end of round 0.
  - Cycle counts are identical to encrypt.
  - decrypt=0 behaves exactly as the undefined build.
- Not defined: no decrypt port; encrypt order only.

Test Plan:
- Reset then load=1, key_mode=00, defaults → round_start pulses at relative cycles 0 (round 0), 1, 5, 9, …, 37; round_last high for cycles 37..40; done rises at cycle 41; nr=10.
- key_mode=10 and 01 → done at cycles 57 and 49; round reaches 14 and 12 and never exceeds them; key_mode=11 → behaves as 00 (done at 41).
- Hold load=1 through DONE for 600 cycles → done stays high and no restart. Drop load at cycle 600 → IDLE on the next edge. Drop load at hold cycle 100 instead → IDLE only after hold cycle 510.
- nreset=0 during ROUND round 5 → next edge: IDLE, all outputs at reset values; a later load gives a clean 41-cycle run.
- ROUND_CYCLES=1, DONE_HOLD=1 → round_start high every cycle of INIT/ROUND, done at cycle 11 for 1 cycle when load=0.
- AES_SEQ_DECRYPT_EN, decrypt=1, key_mode=00 → rounds 10, 9, …, 0; round_last high during round 0; done at cycle 41.
